// File: rtl/sm_dut_mc.sv
// Multi-channel burst accumulator: each channel sums BURST samples, and completed sums are
// arbitrated round-robin onto one valid/ready output. Optional early flush: SM_DUT_MC_FLUSH_EN.

module sm_dut_mc_ch #(
    parameter int IW    = 8,
    parameter int BURST = 4,
    parameter int OW    = 10,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dval,
    input  logic [IW-1:0] din,
    input  logic          grant,
`ifdef SM_DUT_MC_FLUSH_EN
    input  logic          flush,
    output logic [LW-1:0] len,
`endif
    output logic          rdy,
    output logic          full,
    output logic [OW-1:0] sum
);
    typedef enum logic {S_ACC, S_FULL} st_t;

    st_t           st_q;
    logic [LW-1:0] cnt_q;
    logic [OW-1:0] sum_q;
    logic          acc;
    logic [LW-1:0] cnt_inc;
    logic [OW-1:0] sum_inc;

    assign acc     = dval && (st_q == S_ACC);
    assign cnt_inc = cnt_q + 1'b1;
    assign sum_inc = sum_q + {{(OW-IW){1'b0}}, din};

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= S_ACC;
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            case (st_q)
                S_ACC: begin
                    if (acc) begin
                        sum_q <= sum_inc;
                        cnt_q <= cnt_inc;
                    end
                    if (acc && cnt_inc == LW'(BURST))
                        st_q <= S_FULL;
`ifdef SM_DUT_MC_FLUSH_EN
                    // A beat coinciding with flush is already folded into sum/cnt above.
                    else if (flush && (acc || cnt_q != '0))
                        st_q <= S_FULL;
`endif
                end
                S_FULL: begin
                    if (grant) begin
                        st_q  <= S_ACC;
                        cnt_q <= '0;
                        sum_q <= '0;
                    end
                end
                default: st_q <= S_ACC;
            endcase
        end
    end

    assign rdy  = (st_q == S_ACC);
    assign full = (st_q == S_FULL);
    assign sum  = sum_q;
`ifdef SM_DUT_MC_FLUSH_EN
    assign len  = cnt_q;
`endif
endmodule

module sm_dut_mc #(
    parameter int  NCH   = 2,
    parameter int  IW    = 8,
    parameter int  BURST = 4,
    localparam int OW    = IW + $clog2(BURST),
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LW    = $clog2(BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          i_dval,
    output logic [NCH-1:0]          i_rdy,
    input  logic [NCH-1:0][IW-1:0]  i,
`ifdef SM_DUT_MC_FLUSH_EN
    input  logic [NCH-1:0]          i_flush,
    output logic [LW-1:0]           o_len,
`endif
    output logic                    o_dval,
    input  logic                    o_rdy,
    output logic [OW-1:0]           o,
    output logic [CW-1:0]           o_ch
);
    logic [NCH-1:0]         full;
    logic [NCH-1:0]         gnt;
    logic [NCH-1:0][OW-1:0] sums;
    logic                   slot_free;
    logic                   found;
    logic [CW-1:0]          gnt_idx;
    logic [CW-1:0]          last_q;
    logic                   o_dval_q;
    logic [OW-1:0]          o_q;
    logic [CW-1:0]          o_ch_q;
`ifdef SM_DUT_MC_FLUSH_EN
    logic [NCH-1:0][LW-1:0] lens;
    logic [LW-1:0]          o_len_q;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        sm_dut_mc_ch #(.IW(IW), .BURST(BURST), .OW(OW), .LW(LW)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .dval  (i_dval[k]),
            .din   (i[k]),
            .grant (gnt[k]),
`ifdef SM_DUT_MC_FLUSH_EN
            .flush (i_flush[k]),
            .len   (lens[k]),
`endif
            .rdy   (i_rdy[k]),
            .full  (full[k]),
            .sum   (sums[k])
        );
    end

    assign slot_free = !o_dval_q || o_rdy;

    // First FULL channel after the last grant, wrapping; nothing granted while the slot is busy.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        if (slot_free) begin
            for (int j = 1; j <= NCH; j++) begin
                if (!found && full[(int'(last_q) + j) % NCH]) begin
                    found   = 1'b1;
                    gnt_idx = CW'((int'(last_q) + j) % NCH);
                end
            end
        end
        if (found)
            gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_dval_q <= 1'b0;
            o_q      <= '0;
            o_ch_q   <= '0;
            last_q   <= CW'(NCH - 1);
`ifdef SM_DUT_MC_FLUSH_EN
            o_len_q  <= '0;
`endif
        end else if (slot_free) begin
            if (found) begin
                o_dval_q <= 1'b1;
                o_q      <= sums[gnt_idx];
                o_ch_q   <= gnt_idx;
                last_q   <= gnt_idx;
`ifdef SM_DUT_MC_FLUSH_EN
                o_len_q  <= lens[gnt_idx];
`endif
            end else begin
                o_dval_q <= 1'b0;
            end
        end
    end

    assign o_dval = o_dval_q;
    assign o      = o_q;
    assign o_ch   = o_ch_q;
`ifdef SM_DUT_MC_FLUSH_EN
    assign o_len  = o_len_q;
`endif
endmodule

// File: tb/tb_sm_dut_mc.sv
// Directed bench for sm_dut_mc (NCH=2, IW=8, BURST=4); flush scenario runs when SM_DUT_MC_FLUSH_EN is defined.

module tb_sm_dut_mc;
    localparam int NCH = 2, IW = 8, BURST = 4, OW = 10, CW = 1, LW = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NCH-1:0]         i_dval = '0;
    logic [NCH-1:0]         i_rdy;
    logic [NCH-1:0][IW-1:0] din = '0;
    logic                   o_dval;
    logic                   o_rdy = 1'b1;
    logic [OW-1:0]          o;
    logic [CW-1:0]          o_ch;
`ifdef SM_DUT_MC_FLUSH_EN
    logic [NCH-1:0]         i_flush = '0;
    logic [LW-1:0]          o_len;
`endif
    int checks = 0, failures = 0;

    sm_dut_mc #(.NCH(NCH), .IW(IW), .BURST(BURST)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_dval (i_dval),
        .i_rdy  (i_rdy),
        .i      (din),
`ifdef SM_DUT_MC_FLUSH_EN
        .i_flush(i_flush),
        .o_len  (o_len),
`endif
        .o_dval (o_dval),
        .o_rdy  (o_rdy),
        .o      (o),
        .o_ch   (o_ch)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_dval = NCH'($urandom);
            din[0] = IW'($urandom);
            din[1] = IW'($urandom);
            tick();
            checks++;
            if ({o_dval, o_ch, o, i_rdy} !== {1'b0, 1'b0, 10'd0, 2'b11}) begin
                failures++;
                $display("FAIL reset_c%0d got dval=%b ch=%0d o=%0d rdy=%b exp dval=0 ch=0 o=0 rdy=11",
                         c, o_dval, o_ch, o, i_rdy);
            end
`ifdef SM_DUT_MC_FLUSH_EN
            checks++;
            if (o_len !== 3'd0) begin
                failures++;
                $display("FAIL reset_len got=%0d exp=0", o_len);
            end
`endif
        end
        rst    = 1'b0;
        i_dval = '0;
    endtask

    task automatic test_single_burst;
        o_rdy  = 1'b1;
        i_dval = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            din[0] = IW'(k);
            tick();
            checks++;
            if ({o_dval, i_rdy} !== {1'b0, (k == 4) ? 2'b10 : 2'b11}) begin
                failures++;
                $display("FAIL burst_beat%0d got dval=%b rdy=%b exp dval=0 rdy=%b",
                         k, o_dval, i_rdy, (k == 4) ? 2'b10 : 2'b11);
            end
        end
        i_dval = '0;
        tick();
        checks++;
        if ({o_dval, o_ch, o, i_rdy} !== {1'b1, 1'b0, 10'd10, 2'b11}) begin
            failures++;
            $display("FAIL burst_out got dval=%b ch=%0d o=%0d rdy=%b exp 1/0/10/11", o_dval, o_ch, o, i_rdy);
        end
        tick();
        checks++;
        if (o_dval !== 1'b0) begin
            failures++;
            $display("FAIL burst_drop got dval=%b exp 0", o_dval);
        end
    endtask

    task automatic test_max_sum;
        i_dval = 2'b10;
        din[1] = 8'd255;
        repeat (4) tick();
        i_dval = '0;
        tick();
        checks++;
        if ({o_dval, o_ch, o} !== {1'b1, 1'b1, 10'd1020}) begin
            failures++;
            $display("FAIL max_sum got dval=%b ch=%0d o=%0d exp 1/1/1020", o_dval, o_ch, o);
        end
        tick();
        checks++;
        if (o_dval !== 1'b0) begin
            failures++;
            $display("FAIL max_drop got dval=%b exp 0", o_dval);
        end
    endtask

    task automatic test_backpressure;
        o_rdy  = 1'b0;
        i_dval = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            din[0] = IW'(k);
            din[1] = IW'(k + 4);
            tick();
        end
        checks++;
        if (i_rdy !== 2'b00) begin
            failures++;
            $display("FAIL bp_full got rdy=%b exp 00", i_rdy);
        end
        i_dval = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({o_dval, o_ch, o, i_rdy} !== {1'b1, 1'b0, 10'd10, 2'b01}) begin
                failures++;
                $display("FAIL bp_hold_c%0d got dval=%b ch=%0d o=%0d rdy=%b exp 1/0/10/01",
                         c, o_dval, o_ch, o, i_rdy);
            end
        end
        o_rdy = 1'b1;
        tick();
        checks++;
        if ({o_dval, o_ch, o, i_rdy} !== {1'b1, 1'b1, 10'd26, 2'b11}) begin
            failures++;
            $display("FAIL bp_next got dval=%b ch=%0d o=%0d rdy=%b exp 1/1/26/11", o_dval, o_ch, o, i_rdy);
        end
        tick();
        checks++;
        if (o_dval !== 1'b0) begin
            failures++;
            $display("FAIL bp_drop got dval=%b exp 0", o_dval);
        end
    endtask

    task automatic test_reset_mid_burst;
        i_dval = 2'b01;
        din[0] = 8'd7;
        repeat (2) tick();
        i_dval = '0;
        rst    = 1'b1;
        tick();
        checks++;
        if ({o_dval, i_rdy} !== {1'b0, 2'b11}) begin
            failures++;
            $display("FAIL midrst got dval=%b rdy=%b exp 0/11", o_dval, i_rdy);
        end
        rst    = 1'b0;
        i_dval = 2'b01;
        din[0] = 8'd1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (o_dval !== 1'b0) begin
                failures++;
                $display("FAIL midrst_beat%0d got dval=%b exp 0", k, o_dval);
            end
        end
        i_dval = '0;
        tick();
        checks++;
        if ({o_dval, o_ch, o} !== {1'b1, 1'b0, 10'd4}) begin
            failures++;
            $display("FAIL midrst_out got dval=%b ch=%0d o=%0d exp 1/0/4", o_dval, o_ch, o);
        end
        tick();
        checks++;
        if (o_dval !== 1'b0) begin
            failures++;
            $display("FAIL midrst_drop got dval=%b exp 0", o_dval);
        end
    endtask

`ifdef SM_DUT_MC_FLUSH_EN
    task automatic test_flush;
        i_dval = 2'b10;
        din[1] = 8'd3;
        repeat (2) tick();
        i_dval  = '0;
        i_flush = 2'b10;
        tick();
        checks++;
        if ({o_dval, i_rdy} !== {1'b0, 2'b01}) begin
            failures++;
            $display("FAIL flush_full got dval=%b rdy=%b exp 0/01", o_dval, i_rdy);
        end
        i_flush = '0;
        tick();
        checks++;
        if ({o_dval, o_ch, o, o_len} !== {1'b1, 1'b1, 10'd6, 3'd2}) begin
            failures++;
            $display("FAIL flush_out got dval=%b ch=%0d o=%0d len=%0d exp 1/1/6/2", o_dval, o_ch, o, o_len);
        end
        i_flush = 2'b01;
        tick();
        i_flush = '0;
        tick();
        checks++;
        if ({o_dval, i_rdy} !== {1'b0, 2'b11}) begin
            failures++;
            $display("FAIL flush_empty got dval=%b rdy=%b exp 0/11", o_dval, i_rdy);
        end
        i_dval = 2'b10;
        din[1] = 8'd1;
        repeat (4) tick();
        i_dval = '0;
        tick();
        checks++;
        if ({o_dval, o_ch, o, o_len} !== {1'b1, 1'b1, 10'd4, 3'd4}) begin
            failures++;
            $display("FAIL flush_fulllen got dval=%b ch=%0d o=%0d len=%0d exp 1/1/4/4", o_dval, o_ch, o, o_len);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_max_sum();
        test_backpressure();
        test_reset_mid_burst();
`ifdef SM_DUT_MC_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
